tamper_response_ctrl: RTL and testbench
=======================================

Name: tamper_response_ctrl

Overview:
Fabric-side consumer of the SmartFusion2 tamper macro. Synchronizes the macro's detection flags, category and change strobe, then classifies each event by severity. An escalation FSM drives the macro's active-low response inputs: LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, RESET_N and ZEROIZE_N. It also exposes sticky status, last category and a fail counter to a fabric CPU register bank.

Parameters:
FAIL_THRESHOLD, 3, DETECT_FAIL count that escalates to lockdown (1..2^FAIL_CNT_W-1)
FAIL_CNT_W, 4, fail counter width
IO_DISABLE_DELAY, 16, cycles from LOCKDOWN_ALL_N low to DISABLE_ALL_IOS_N low (1..255)
RESET_PULSE_LEN, 8, RESET_N low pulse length in cycles (1..255)

Ports:
CLK  in  1  single clock
RESET  in  1  synchronous, active-high reset
JTAG_ACTIVE, LOCK_TAMPER_DETECT, MESH_SHORT_ERROR, CLK_ERROR, DETECT_ATTEMPT, DETECT_FAIL, DIGEST_ERROR, POWERUP_DIGEST_ERROR, SC_ROM_DIGEST_ERROR, TAMPER_CHANGE_STROBE  in  1 each  tamper macro flags, asynchronous
DETECT_CATEGORY  in  4  tamper macro category, asynchronous
ALERT_ACK  in  1  returns ALERT to IDLE
STATUS_CLR  in  1  clears sticky status
LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, RESET_N, ZEROIZE_N  out  1 each  responses to the macro, active low
STATE  out  3  FSM state encoding
STICKY_STATUS  out  9  one bit per flag, in the input order listed above (excluding the strobe)
LAST_CATEGORY  out  4  category latched on the last strobe
FAIL_COUNT  out  FAIL_CNT_W  saturating DETECT_FAIL count
IRQ  out  1  single-cycle pulse on every state change

Behaviour:
- Reset:
  - All _N outputs are 1.
  - STATE=IDLE(0).
  - STICKY_STATUS=0, LAST_CATEGORY=0, FAIL_COUNT=0, IRQ=0.
  - Synchronizer and delay counters are cleared.
- Input path:
  - All tamper inputs pass through a 2-flop synchronizer.
  - A strobe rising edge is detected on the synchronized strobe.
  - Severity is registered one cycle later; FSM state and outputs update the next cycle.
  - Fixed latency: 4 rising edges from input change to output change.
- Strobe edge:
  - LAST_CATEGORY is loaded.
  - If synchronized DETECT_FAIL=1, FAIL_COUNT increments, saturating at all-ones. It is cleared only by RESET.
- Severity classes (highest active class wins):
  - ZEROIZE: MESH_SHORT_ERROR, SC_ROM_DIGEST_ERROR.
  - LOCK: DIGEST_ERROR, POWERUP_DIGEST_ERROR, CLK_ERROR, or FAIL_COUNT>=FAIL_THRESHOLD.
  - ALERT: JTAG_ACTIVE, LOCK_TAMPER_DETECT, DETECT_ATTEMPT.
- Sticky status:
  - A bit sets while its synchronized flag is high.
  - STATUS_CLR clears it; set wins over clear in the same cycle.
- FSM states:
  - IDLE(0): all outputs inactive.
    - ALERT class -> ALERT.
    - LOCK class -> LOCK_WAIT.
    - ZEROIZE class -> ZEROIZE.
  - ALERT(1): outputs inactive.
    - ALERT_ACK with no active event -> IDLE.
    - A new event in the same cycle as ALERT_ACK keeps ALERT.
    - Higher class -> its state.
  - LOCK_WAIT(2): LOCKDOWN_ALL_N=0; counts IO_DISABLE_DELAY cycles -> IO_OFF.
  - IO_OFF(3): DISABLE_ALL_IOS_N=0 added; RESET_N=0 for RESET_PULSE_LEN cycles -> LOCKED.
  - LOCKED(4): LOCKDOWN_ALL_N=0 and DISABLE_ALL_IOS_N=0, RESET_N=1. Terminal until RESET.
  - ZEROIZE(5): all four _N outputs =0 except RESET_N=1. Terminal until RESET.
- Escalation rules:
  - Escalation is monotonic. A ZEROIZE-class event in any state enters ZEROIZE on the next FSM edge and aborts in-progress counters.
  - Lower-class events in higher states update sticky status only.
  - ALERT_ACK is ignored outside ALERT.
- IRQ pulses for one cycle on every STATE change.
- RESET mid-sequence returns to the reset values in the next cycle.

Optional Feature:
TAMPER_ZEROIZE_EN
- Defined: behaviour as above.
- Undefined:
  - ZEROIZE-class events are treated as LOCK class.
  - State ZEROIZE is unreachable.
  - ZEROIZE_N is tied to 1.
  - Sticky bits still record the events.

Decomposition:
- Package tamper_resp_pkg holds:
  - the state enum (IDLE..ZEROIZE, 3 bits)
  - the severity enum (NONE, ALERT, LOCK, ZEROIZE)
  - the sticky bit index constants
- Sub-module tamper_sync: parameterized-width 2-flop synchronizer plus strobe rising-edge detector.

Test Plan:
1. Assert RESET 2 cycles -> all _N=1, STATE=0, FAIL_COUNT=0, STICKY_STATUS=0.
2. JTAG_ACTIVE=1 -> 4 cycles later STATE=1, IRQ one-cycle pulse, STICKY_STATUS[0]=1. Drop JTAG_ACTIVE, then ALERT_ACK -> STATE=0.
3. Three strobes with DETECT_FAIL=1 -> FAIL_COUNT=3 and LOCKDOWN_ALL_N=0. DISABLE_ALL_IOS_N=0 16 cycles later, RESET_N low exactly 8 cycles, then STATE=4.
4. JTAG_ACTIVE and DIGEST_ERROR asserted in the same cycle -> STATE goes 0->2 directly; ALERT is never entered.
5. MESH_SHORT_ERROR at cycle 5 of LOCK_WAIT:
   - With TAMPER_ZEROIZE_EN: STATE=5 and ZEROIZE_N=0 within 4 cycles.
   - Without it: the lockdown sequence continues and ZEROIZE_N stays 1.
6. STATUS_CLR while CLK_ERROR is held high -> STICKY_STATUS[3] stays 1. After CLK_ERROR drops, STATUS_CLR clears it.

Source files
------------

// File: rtl/tamper_resp_pkg.sv
// rtl/tamper_resp_pkg.sv - shared types and constants for tamper_response_ctrl
//
// Contents:
//   state_e   escalation FSM state encoding (IDLE..ZEROIZE, 3 bits)
//   sev_e     event severity class (NONE, ALERT, LOCK, ZEROIZE)
//   STK_*     bit positions of the tamper flags in the sticky/flag vectors
package tamper_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ALERT     = 3'd1,
        ST_LOCK_WAIT = 3'd2,
        ST_IO_OFF    = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_ZEROIZE   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SEV_NONE    = 2'd0,
        SEV_ALERT   = 2'd1,
        SEV_LOCK    = 2'd2,
        SEV_ZEROIZE = 2'd3
    } sev_e;

    localparam int NUM_FLAGS = 9;

    localparam int STK_JTAG_ACTIVE          = 0;
    localparam int STK_LOCK_TAMPER_DETECT   = 1;
    localparam int STK_MESH_SHORT_ERROR     = 2;
    localparam int STK_CLK_ERROR            = 3;
    localparam int STK_DETECT_ATTEMPT       = 4;
    localparam int STK_DETECT_FAIL          = 5;
    localparam int STK_DIGEST_ERROR         = 6;
    localparam int STK_POWERUP_DIGEST_ERROR = 7;
    localparam int STK_SC_ROM_DIGEST_ERROR  = 8;

endpackage

// File: rtl/tamper_sync.sv
// rtl/tamper_sync.sv - 2-flop synchronizer bus plus strobe rising-edge detector
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   async_bus     W asynchronous level inputs
//   strobe        asynchronous change strobe
//   sync_bus      async_bus after two flops
//   strobe_rise   one-cycle pulse, aligned with sync_bus, on a strobe 0->1
module tamper_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_bus,
    input  logic         strobe,
    output logic [W-1:0] sync_bus,
    output logic         strobe_rise
);

    logic [W-1:0] meta;
    logic [1:0]   strobe_meta;
    logic         strobe_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta        <= '0;
            sync_bus    <= '0;
            strobe_meta <= '0;
            strobe_prev <= 1'b0;
        end else begin
            meta        <= async_bus;
            sync_bus    <= meta;
            strobe_meta <= {strobe_meta[0], strobe};
            strobe_prev <= strobe_meta[1];
        end
    end

    // strobe_meta[1] is the synchronized strobe; compare against its last value
    assign strobe_rise = strobe_meta[1] & ~strobe_prev;

endmodule

// File: rtl/tamper_response_ctrl.sv
// rtl/tamper_response_ctrl.sv - tamper event classifier and escalation FSM
//
// Optional feature macro: TAMPER_ZEROIZE_EN. When undefined, zeroize-class
// events are handled as lock-class, ZEROIZE is unreachable, ZEROIZE_N = 1.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   JTAG_ACTIVE .. SC_ROM_DIGEST_ERROR, TAMPER_CHANGE_STROBE, DETECT_CATEGORY
//                              asynchronous tamper macro outputs
//   ALERT_ACK                  returns ALERT to IDLE when no event is active
//   STATUS_CLR                 clears sticky status (set has priority)
//   LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, RESET_N, ZEROIZE_N
//                              active-low responses to the tamper macro
//   STATE                      FSM state
//   STICKY_STATUS              sticky flag record, bit order as flag inputs
//   LAST_CATEGORY              category captured on the last strobe edge
//   FAIL_COUNT                 saturating count of strobes with DETECT_FAIL
//   IRQ                        one-cycle pulse on every state change
module tamper_response_ctrl
    import tamper_resp_pkg::*;
#(
    parameter int FAIL_THRESHOLD   = 3,
    parameter int FAIL_CNT_W       = 4,
    parameter int IO_DISABLE_DELAY = 16,
    parameter int RESET_PULSE_LEN  = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  JTAG_ACTIVE,
    input  logic                  LOCK_TAMPER_DETECT,
    input  logic                  MESH_SHORT_ERROR,
    input  logic                  CLK_ERROR,
    input  logic                  DETECT_ATTEMPT,
    input  logic                  DETECT_FAIL,
    input  logic                  DIGEST_ERROR,
    input  logic                  POWERUP_DIGEST_ERROR,
    input  logic                  SC_ROM_DIGEST_ERROR,
    input  logic                  TAMPER_CHANGE_STROBE,
    input  logic [3:0]            DETECT_CATEGORY,
    input  logic                  ALERT_ACK,
    input  logic                  STATUS_CLR,
    output logic                  LOCKDOWN_ALL_N,
    output logic                  DISABLE_ALL_IOS_N,
    output logic                  RESET_N,
    output logic                  ZEROIZE_N,
    output logic [2:0]            STATE,
    output logic [NUM_FLAGS-1:0]  STICKY_STATUS,
    output logic [3:0]            LAST_CATEGORY,
    output logic [FAIL_CNT_W-1:0] FAIL_COUNT,
    output logic                  IRQ
);

    localparam int SYNC_W = NUM_FLAGS + 4;

    logic [SYNC_W-1:0]    raw_bus;
    logic [SYNC_W-1:0]    sync_bus;
    logic [NUM_FLAGS-1:0] flags;
    logic [3:0]           category;
    logic                 strobe_rise;

    assign raw_bus = {DETECT_CATEGORY, SC_ROM_DIGEST_ERROR, POWERUP_DIGEST_ERROR,
                      DIGEST_ERROR, DETECT_FAIL, DETECT_ATTEMPT, CLK_ERROR,
                      MESH_SHORT_ERROR, LOCK_TAMPER_DETECT, JTAG_ACTIVE};

    tamper_sync #(.W(SYNC_W)) u_sync (
        .clk         (CLK),
        .reset       (RESET),
        .async_bus   (raw_bus),
        .strobe      (TAMPER_CHANGE_STROBE),
        .sync_bus    (sync_bus),
        .strobe_rise (strobe_rise)
    );

    assign flags    = sync_bus[NUM_FLAGS-1:0];
    assign category = sync_bus[SYNC_W-1:NUM_FLAGS];

    // Severity classification on synchronized flags
    logic zero_hit, lock_hit, alert_hit;
    sev_e sev_d, sev_q;

    assign zero_hit  = flags[STK_MESH_SHORT_ERROR] | flags[STK_SC_ROM_DIGEST_ERROR];
    assign lock_hit  = flags[STK_DIGEST_ERROR] | flags[STK_POWERUP_DIGEST_ERROR]
                     | flags[STK_CLK_ERROR]
                     | (FAIL_COUNT >= FAIL_CNT_W'(FAIL_THRESHOLD));
    assign alert_hit = flags[STK_JTAG_ACTIVE] | flags[STK_LOCK_TAMPER_DETECT]
                     | flags[STK_DETECT_ATTEMPT];

    always_comb begin
        sev_d = SEV_NONE;
`ifdef TAMPER_ZEROIZE_EN
        if (zero_hit)
            sev_d = SEV_ZEROIZE;
        else if (lock_hit)
            sev_d = SEV_LOCK;
`else
        if (zero_hit || lock_hit)
            sev_d = SEV_LOCK;
`endif
        else if (alert_hit)
            sev_d = SEV_ALERT;
    end

    // Status registers and severity pipeline stage
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sev_q         <= SEV_NONE;
            STICKY_STATUS <= '0;
            LAST_CATEGORY <= '0;
            FAIL_COUNT    <= '0;
        end else begin
            sev_q         <= sev_d;
            STICKY_STATUS <= flags | (STATUS_CLR ? '0 : STICKY_STATUS);
            if (strobe_rise) begin
                LAST_CATEGORY <= category;
                if (flags[STK_DETECT_FAIL] && (FAIL_COUNT != '1))
                    FAIL_COUNT <= FAIL_COUNT + 1'b1;
            end
        end
    end

    // Escalation FSM: next state and phase counter
    state_e     state, nxt_state;
    logic [7:0] cnt, nxt_cnt;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                case (sev_q)
                    SEV_ALERT:   nxt_state = ST_ALERT;
                    SEV_LOCK:    nxt_state = ST_LOCK_WAIT;
                    SEV_ZEROIZE: nxt_state = ST_ZEROIZE;
                    default:     nxt_state = ST_IDLE;
                endcase
            end
            ST_ALERT: begin
                if (sev_q == SEV_ZEROIZE)
                    nxt_state = ST_ZEROIZE;
                else if (sev_q == SEV_LOCK)
                    nxt_state = ST_LOCK_WAIT;
                else if (ALERT_ACK && (sev_q == SEV_NONE))
                    nxt_state = ST_IDLE;
            end
            ST_LOCK_WAIT: begin
                if (sev_q == SEV_ZEROIZE)
                    nxt_state = ST_ZEROIZE;
                else if (cnt == 8'(IO_DISABLE_DELAY - 1))
                    nxt_state = ST_IO_OFF;
                else
                    nxt_cnt = cnt + 8'd1;
            end
            ST_IO_OFF: begin
                if (sev_q == SEV_ZEROIZE)
                    nxt_state = ST_ZEROIZE;
                else if (cnt == 8'(RESET_PULSE_LEN - 1))
                    nxt_state = ST_LOCKED;
                else
                    nxt_cnt = cnt + 8'd1;
            end
            ST_LOCKED: begin
                if (sev_q == SEV_ZEROIZE)
                    nxt_state = ST_ZEROIZE;
            end
            ST_ZEROIZE: nxt_state = ST_ZEROIZE;
            default:    nxt_state = ST_IDLE;
        endcase
        // every phase starts its count from zero; a zeroize abort drops it
        if (nxt_state != state)
            nxt_cnt = '0;
    end

    // Outputs are decoded from the next state so they change with STATE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            IRQ               <= 1'b0;
            LOCKDOWN_ALL_N    <= 1'b1;
            DISABLE_ALL_IOS_N <= 1'b1;
            RESET_N           <= 1'b1;
        end else begin
            state             <= nxt_state;
            cnt               <= nxt_cnt;
            IRQ               <= (nxt_state != state);
            LOCKDOWN_ALL_N    <= !(nxt_state inside {ST_LOCK_WAIT, ST_IO_OFF, ST_LOCKED, ST_ZEROIZE});
            DISABLE_ALL_IOS_N <= !(nxt_state inside {ST_IO_OFF, ST_LOCKED, ST_ZEROIZE});
            RESET_N           <= (nxt_state != ST_IO_OFF);
        end
    end

`ifdef TAMPER_ZEROIZE_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            ZEROIZE_N <= 1'b1;
        else
            ZEROIZE_N <= (nxt_state != ST_ZEROIZE);
    end
`else
    assign ZEROIZE_N = 1'b1;
`endif

    assign STATE = state;

endmodule

// File: tb/tb_tamper_response_ctrl.sv
// tb/tb_tamper_response_ctrl.sv - self-checking bench for tamper_response_ctrl
module tb_tamper_response_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [8:0] flags;
    logic       strobe;
    logic [3:0] category;
    logic       ALERT_ACK;
    logic       STATUS_CLR;
    logic       LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, RESET_N, ZEROIZE_N;
    logic [2:0] STATE;
    logic [8:0] STICKY_STATUS;
    logic [3:0] LAST_CATEGORY;
    logic [3:0] FAIL_COUNT;
    logic       IRQ;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    tamper_response_ctrl dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .JTAG_ACTIVE          (flags[0]),
        .LOCK_TAMPER_DETECT   (flags[1]),
        .MESH_SHORT_ERROR     (flags[2]),
        .CLK_ERROR            (flags[3]),
        .DETECT_ATTEMPT       (flags[4]),
        .DETECT_FAIL          (flags[5]),
        .DIGEST_ERROR         (flags[6]),
        .POWERUP_DIGEST_ERROR (flags[7]),
        .SC_ROM_DIGEST_ERROR  (flags[8]),
        .TAMPER_CHANGE_STROBE (strobe),
        .DETECT_CATEGORY      (category),
        .ALERT_ACK            (ALERT_ACK),
        .STATUS_CLR           (STATUS_CLR),
        .LOCKDOWN_ALL_N       (LOCKDOWN_ALL_N),
        .DISABLE_ALL_IOS_N    (DISABLE_ALL_IOS_N),
        .RESET_N              (RESET_N),
        .ZEROIZE_N            (ZEROIZE_N),
        .STATE                (STATE),
        .STICKY_STATUS        (STICKY_STATUS),
        .LAST_CATEGORY        (LAST_CATEGORY),
        .FAIL_COUNT           (FAIL_COUNT),
        .IRQ                  (IRQ)
    );

`ifdef TAMPER_ZEROIZE_EN
    localparam logic [2:0] Z_STATE = 3'd5;
    localparam logic [3:0] Z_OUTS  = 4'b0010;
`else
    localparam logic [2:0] Z_STATE = 3'd2;
    localparam logic [3:0] Z_OUTS  = 4'b0111;
`endif

    typedef struct {
        logic [8:0] flags;
        logic [2:0] st;
        logic [8:0] sticky;
        logic [3:0] outs;
        logic       irq;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [3:0] outs();
        return {LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, RESET_N, ZEROIZE_N};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1; flags = '0; strobe = 1'b0; category = '0;
        ALERT_ACK = 1'b0; STATUS_CLR = 1'b0;
        cyc(2);
        RESET = 1'b0;
    endtask

    task automatic wait_lockdown(output int ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (LOCKDOWN_ALL_N == 1'b0) begin
                ok = 1;
                break;
            end
        end
        check("lockdown_timeout", ok, 1);
    endtask

    initial begin
        int ok;
        int n;

        tbl[0]  = '{9'h001, 3'd1, 9'h001, 4'b1111, 1'b1};
        tbl[1]  = '{9'h002, 3'd1, 9'h002, 4'b1111, 1'b1};
        tbl[2]  = '{9'h010, 3'd1, 9'h010, 4'b1111, 1'b1};
        tbl[3]  = '{9'h008, 3'd2, 9'h008, 4'b0111, 1'b1};
        tbl[4]  = '{9'h040, 3'd2, 9'h040, 4'b0111, 1'b1};
        tbl[5]  = '{9'h080, 3'd2, 9'h080, 4'b0111, 1'b1};
        tbl[6]  = '{9'h041, 3'd2, 9'h041, 4'b0111, 1'b1};
        tbl[7]  = '{9'h004, Z_STATE, 9'h004, Z_OUTS, 1'b1};
        tbl[8]  = '{9'h100, Z_STATE, 9'h100, Z_OUTS, 1'b1};
        tbl[9]  = '{9'h020, 3'd0, 9'h020, 4'b1111, 1'b0};
        tbl[10] = '{9'h00D, Z_STATE, 9'h00D, Z_OUTS, 1'b1};

        // reset values
        do_reset();
        @(negedge CLK);
        check("rst_outs", outs(), 4'b1111);
        check("rst_state", STATE, 0);
        check("rst_fail", FAIL_COUNT, 0);
        check("rst_sticky", STICKY_STATUS, 0);
        check("rst_irq", IRQ, 0);
        check("rst_cat", LAST_CATEGORY, 0);

        // single-event classification table; four-edge latency boundary
        for (int v = 0; v < 11; v++) begin
            do_reset();
            flags = tbl[v].flags;
            cyc(3);
            check($sformatf("v%0d_state_early", v), STATE, 0);
            cyc(1);
            check($sformatf("v%0d_state", v), STATE, tbl[v].st);
            check($sformatf("v%0d_sticky", v), STICKY_STATUS, tbl[v].sticky);
            check($sformatf("v%0d_outs", v), outs(), tbl[v].outs);
            check($sformatf("v%0d_irq", v), IRQ, tbl[v].irq);
        end

        // ALERT entry, ack with event still present, ack after event clears
        do_reset();
        flags = 9'h001;
        cyc(4);
        check("alert_state", STATE, 1);
        check("alert_irq", IRQ, 1);
        cyc(1);
        check("alert_irq_pulse", IRQ, 0);
        ALERT_ACK = 1'b1;
        cyc(1);
        ALERT_ACK = 1'b0;
        check("alert_ack_busy", STATE, 1);
        flags = '0;
        cyc(4);
        ALERT_ACK = 1'b1;
        cyc(1);
        ALERT_ACK = 1'b0;
        check("alert_ack_idle", STATE, 0);
        check("alert_ack_irq", IRQ, 1);
        check("alert_sticky", STICKY_STATUS[0], 1);

        // three DETECT_FAIL strobes escalate to lockdown sequence
        do_reset();
        flags = 9'h020;
        category = 4'hA;
        for (int s = 0; s < 2; s++) begin
            strobe = 1'b1; cyc(2);
            strobe = 1'b0; cyc(2);
        end
        check("fail_cnt2", FAIL_COUNT, 2);
        check("fail_below_thr", STATE, 0);
        strobe = 1'b1; cyc(2);
        strobe = 1'b0;
        wait_lockdown(ok);
        check("fail_cnt3", FAIL_COUNT, 3);
        check("fail_cat", LAST_CATEGORY, 4'hA);
        check("lw_state", STATE, 2);
        ALERT_ACK = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            ALERT_ACK = 1'b0;
            n++;
        end while (DISABLE_ALL_IOS_N && n < 64);
        check("io_delay", n, 16);
        check("io_state", STATE, 3);
        n = 0;
        while (RESET_N == 1'b0 && n < 64) begin
            n++;
            @(negedge CLK);
        end
        check("rst_pulse_len", n, 8);
        check("locked_state", STATE, 4);
        check("locked_outs", outs(), 4'b0011);

        // zeroize-class event during LOCK_WAIT
        do_reset();
        flags = 9'h040;
        wait_lockdown(ok);
        cyc(5);
        flags = 9'h044;
        cyc(4);
`ifdef TAMPER_ZEROIZE_EN
        check("zero_state", STATE, 5);
        check("zero_outs", outs(), 4'b0010);
        cyc(20);
        check("zero_hold", STATE, 5);
        check("zero_rst_n", RESET_N, 1);
`else
        check("nozero_state", STATE, 2);
        check("nozero_n", ZEROIZE_N, 1);
        n = 0;
        while (STATE != 3'd4 && n < 64) begin
            n++;
            @(negedge CLK);
        end
        check("nozero_locked", STATE, 4);
        check("nozero_n_end", ZEROIZE_N, 1);
`endif
        check("zero_sticky", STICKY_STATUS, 9'h044);

        // STATUS_CLR loses to a held flag, then clears once it drops
        do_reset();
        flags = 9'h008;
        cyc(5);
        STATUS_CLR = 1'b1;
        cyc(1);
        STATUS_CLR = 1'b0;
        check("clr_held", STICKY_STATUS[3], 1);
        flags = '0;
        cyc(4);
        STATUS_CLR = 1'b1;
        cyc(1);
        STATUS_CLR = 1'b0;
        check("clr_done", STICKY_STATUS[3], 0);

        // RESET in the middle of the lockdown sequence
        flags = 9'h080;
        wait_lockdown(ok);
        cyc(3);
        RESET = 1'b1;
        flags = '0;
        cyc(1);
        check("midrst_state", STATE, 0);
        check("midrst_outs", outs(), 4'b1111);
        check("midrst_sticky", STICKY_STATUS, 0);
        RESET = 1'b0;
        cyc(6);
        check("midrst_stay", STATE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
